// File: rtl/sprite_blit_if.sv
// Sprite blit controller bus bundle: renderer request/status, sprite ROM port
// and framebuffer write port.
//   master : requester side (drives start/x0/y0, returns rom_q and fb_ready)
//   slave  : blit controller side (drives status, ROM address and FB writes)
interface sprite_blit_if #(
   parameter int unsigned ROM_AW = 9,
   parameter int unsigned FB_AW  = 15
);
   logic              start;
   logic [7:0]        x0;
   logic [6:0]        y0;
   logic              busy;
   logic              done;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_q;
   logic              fb_we;
   logic [FB_AW-1:0]  fb_addr;
   logic [7:0]        fb_data;
   logic              fb_ready;
   logic [8:0]        wr_count;

   modport master (
      output start, x0, y0, rom_q, fb_ready,
      input  busy, done, rom_addr, fb_we, fb_addr, fb_data, wr_count
   );

   modport slave (
      input  start, x0, y0, rom_q, fb_ready,
      output busy, done, rom_addr, fb_we, fb_addr, fb_data, wr_count
   );
endinterface

// File: rtl/sprite_blit_ctrl.sv
// Copies one SPR_W x SPR_H sprite from a 1-cycle-latency sprite ROM into the
// framebuffer at origin (x0, y0), clipping pixels outside FB_W x FB_H.
// Optional colour-key skip is enabled by defining SPRITE_TRANSPARENT_EN.
// Ports:
//   clock        system clock, all logic on posedge
//   reset        synchronous active-high reset
//   bus (slave)  start/x0/y0 request, busy/done/wr_count status,
//                rom_addr/rom_q sprite ROM port, fb_we/fb_addr/fb_data/fb_ready
//                framebuffer write handshake
module sprite_blit_ctrl #(
   parameter int unsigned SPR_W  = 20,
   parameter int unsigned SPR_H  = 20,
   parameter int unsigned ROM_AW = 9,
   parameter int unsigned FB_W   = 160,
   parameter int unsigned FB_H   = 120,
   parameter int unsigned FB_AW  = 15
`ifdef SPRITE_TRANSPARENT_EN
   ,
   parameter logic [7:0]  KEY    = 8'd255
`endif
) (
   input  logic           clock,
   input  logic           reset,
   sprite_blit_if.slave   bus
);

   localparam int unsigned COL_W = $clog2(SPR_W);
   localparam int unsigned ROW_W = $clog2(SPR_H);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fb_we_q, fb_we_d;
   logic [7:0]        x0_q;
   logic [6:0]        y0_q;
   logic [COL_W-1:0]  col_q;
   logic [ROW_W-1:0]  row_q;
   logic [ROM_AW-1:0] rom_addr_q;
   logic [FB_AW-1:0]  fb_addr_q;
   logic [7:0]        fb_data_q;
   logic [8:0]        wr_count_q;

   logic [8:0]        px_c, py_c;
   logic [FB_AW-1:0]  fb_addr_c;
   logic              key_hit_c, skip_c, last_c, adv_c;

   // Pixel position at 9 bits so origin + offset never wraps.
   assign px_c      = 9'(x0_q) + 9'(col_q);
   assign py_c      = 9'(y0_q) + 9'(row_q);
   assign fb_addr_c = FB_AW'(py_c) * FB_AW'(FB_W) + FB_AW'(px_c);

`ifdef SPRITE_TRANSPARENT_EN
   assign key_hit_c = (bus.rom_q == KEY);
`else
   assign key_hit_c = 1'b0;
`endif

   assign skip_c = (px_c >= 9'(FB_W)) || (py_c >= 9'(FB_H)) || key_hit_c;
   assign last_c = (row_q == ROW_W'(SPR_H - 1)) && (col_q == COL_W'(SPR_W - 1));
   // Pixel retires on a skip in WAIT or on the write handshake.
   assign adv_c  = ((state_q == S_WAIT) && skip_c) ||
                   ((state_q == S_WRITE) && bus.fb_ready);

   // State register plus registered status outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fb_we_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fb_we_q <= fb_we_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (skip_c) state_d = last_c ? S_DONE : S_FETCH;
            else        state_d = S_WRITE;
         end
         S_WRITE: if (bus.fb_ready) state_d = last_c ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the next state so they register in step.
   always_comb begin
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fb_we_d = 1'b0;
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
      fb_we_d = (state_d == S_WRITE);
   end

   // Datapath: origin latch, sprite walk, ROM address and write payload.
   // rom_addr is the linear index row*SPR_W+col, so it steps by one per pixel
   // and is already valid during FETCH for the ROM to sample.
   always_ff @(posedge clock) begin
      if (reset) begin
         x0_q       <= '0;
         y0_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         rom_addr_q <= '0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         wr_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  x0_q       <= bus.x0;
                  y0_q       <= bus.y0;
                  col_q      <= '0;
                  row_q      <= '0;
                  rom_addr_q <= '0;
                  wr_count_q <= '0;
               end
            end
            S_WAIT: begin
               if (!skip_c) begin
                  fb_data_q <= bus.rom_q;
                  fb_addr_q <= fb_addr_c;
               end
            end
            S_WRITE: begin
               if (bus.fb_ready) wr_count_q <= wr_count_q + 9'd1;
            end
            default: ;
         endcase

         if (adv_c && !last_c) begin
            rom_addr_q <= rom_addr_q + ROM_AW'(1);
            if (col_q == COL_W'(SPR_W - 1)) begin
               col_q <= '0;
               row_q <= row_q + ROW_W'(1);
            end else begin
               col_q <= col_q + COL_W'(1);
            end
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.fb_we    = fb_we_q;
   assign bus.rom_addr = rom_addr_q;
   assign bus.fb_addr  = fb_addr_q;
   assign bus.fb_data  = fb_data_q;
   assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_sprite_blit_ctrl.sv
// Self-checking bench for sprite_blit_ctrl: directed and randomized blits
// against a per-pixel reference model of the expected write list and cost.
`timescale 1ns/1ps
module tb_sprite_blit_ctrl;

   localparam int SPR_W = 20;
   localparam int SPR_H = 20;
   localparam int FB_W  = 160;
   localparam int FB_H  = 120;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   sprite_blit_if bus ();

   sprite_blit_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous sprite ROM, one cycle read latency.
   logic [7:0] rom_mem [0:511];
   always @(posedge clock) bus.rom_q <= rom_mem[bus.rom_addr];

   int total = 0;
   int bad   = 0;
   int ready_mode = 0;      // 0: always ready, 1: toggle, 2: random
   int busy_cnt, done_cnt, stall_cnt;
   int exp_cost;
   logic [22:0] got_q [$];
   logic [22:0] exp_q [$];

   logic        hold_pending = 1'b0;
   logic [14:0] hold_addr;
   logic [7:0]  hold_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #2;
   endtask

   task automatic clear_stats();
      busy_cnt  = 0;
      done_cnt  = 0;
      stall_cnt = 0;
      got_q.delete();
   endtask

   // Reference: walk the sprite, decide write/skip per pixel, sum the cost.
   function automatic void build_expected(input int x, input int y);
      exp_q.delete();
      exp_cost = 0;
      for (int r = 0; r < SPR_H; r++) begin
         for (int c = 0; c < SPR_W; c++) begin
            int         px;
            int         py;
            logic [7:0] v;
            bit         keep;
            px   = x + c;
            py   = y + r;
            v    = rom_mem[r * SPR_W + c];
            keep = (px < FB_W) && (py < FB_H);
`ifdef SPRITE_TRANSPARENT_EN
            if (v == 8'd255) keep = 1'b0;
`endif
            if (keep) begin
               exp_q.push_back({15'(py * FB_W + px), v});
               exp_cost += 3;
            end else begin
               exp_cost += 2;
            end
         end
      end
   endfunction

   // Drive fb_ready each negedge, then sample the cycle the DUT will clock.
   initial begin
      bus.fb_ready = 1'b0;
      forever begin
         @(negedge clock);
         case (ready_mode)
            0:       bus.fb_ready = 1'b1;
            1:       bus.fb_ready = ~bus.fb_ready;
            default: bus.fb_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (reset) begin
            hold_pending = 1'b0;
         end else begin
            if (hold_pending) begin
               chk("stall_hold_we",   32'(bus.fb_we),   32'd1);
               chk("stall_hold_addr", 32'(bus.fb_addr), 32'(hold_addr));
               chk("stall_hold_data", 32'(bus.fb_data), 32'(hold_data));
            end
            hold_pending = bus.fb_we && !bus.fb_ready;
            hold_addr    = bus.fb_addr;
            hold_data    = bus.fb_data;
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            if (bus.fb_we && !bus.fb_ready) stall_cnt++;
            if (bus.fb_we && bus.fb_ready) got_q.push_back({bus.fb_addr, bus.fb_data});
         end
      end
   end

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({tag, " done_seen"}, 32'(bus.done), 32'd1);
   endtask

   task automatic check_blit(input string tag);
      int nmis;
      int n;
      nmis = 0;
      chk({tag, " done_pulses"}, done_cnt, 1);
      chk({tag, " writes"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) nmis++;
      chk({tag, " write_mismatches"}, nmis, 0);
      chk({tag, " wr_count"}, 32'(bus.wr_count), exp_q.size());
      chk({tag, " cycles"}, busy_cnt - 1, exp_cost + stall_cnt);
   endtask

   task automatic run_blit(input int x, input int y, input string tag);
      clear_stats();
      build_expected(x, y);
      bus.x0    = 8'(x);
      bus.y0    = 7'(y);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(tag, 6000);
      check_blit(tag);
      tick();
      chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " idle_done"}, 32'(bus.done), 32'd0);
      chk({tag, " wr_count_hold"}, 32'(bus.wr_count), exp_q.size());
   endtask

   function automatic int first_addr();
      return (got_q.size() > 0) ? int'(got_q[0][22:8]) : -1;
   endfunction

   function automatic int last_addr();
      return (got_q.size() > 0) ? int'(got_q[got_q.size() - 1][22:8]) : -1;
   endfunction

   task automatic fill_random_rom();
      for (int i = 0; i < 512; i++)
         rom_mem[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.x0    = '0;
      bus.y0    = '0;
      for (int i = 0; i < 512; i++) rom_mem[i] = 8'd232;
      clear_stats();

      // Reset values.
      tick(); tick(); tick();
      chk("rst_busy",     32'(bus.busy),     32'd0);
      chk("rst_done",     32'(bus.done),     32'd0);
      chk("rst_fb_we",    32'(bus.fb_we),    32'd0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_fb_addr",  32'(bus.fb_addr),  32'd0);
      chk("rst_fb_data",  32'(bus.fb_data),  32'd0);
      chk("rst_wr_count", 32'(bus.wr_count), 32'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_busy", 32'(bus.busy), 32'd0);

      // Full sprite at origin, no stalls.
      ready_mode = 0;
      run_blit(0, 0, "full00");
      chk("full00 first_addr", first_addr(), 0);
      chk("full00 last_addr",  last_addr(),  3059);
      chk("full00 busy_span",  busy_cnt - 1, 1200);

      // Bottom-right corner, mostly clipped.
      run_blit(150, 110, "corner");
      chk("corner first_addr", first_addr(), 17750);
      chk("corner last_addr",  last_addr(),  19199);

      // Colour-key pattern: 255 at even ROM addresses, 232 at odd.
      for (int i = 0; i < 512; i++) rom_mem[i] = (i % 2 == 0) ? 8'd255 : 8'd232;
      run_blit(0, 0, "keyed");
`ifdef SPRITE_TRANSPARENT_EN
      chk("keyed first_addr", first_addr(), 1);
      chk("keyed busy_span",  busy_cnt - 1, 1000);
`else
      chk("keyed first_addr", first_addr(), 0);
      chk("keyed busy_span",  busy_cnt - 1, 1200);
`endif

      // fb_ready toggling every cycle.
      fill_random_rom();
      ready_mode = 1;
      run_blit(0, 0, "toggle");
      chk("toggle stalled", 32'(stall_cnt > 0), 32'd1);

      // Reset after the 37th write.
      ready_mode = 0;
      fill_random_rom();
      clear_stats();
      bus.x0    = 8'd0;
      bus.y0    = 7'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      n = 0;
      while (got_q.size() < 37 && n < 500) begin
         tick();
         n++;
      end
      chk("abort writes_before", got_q.size(), 37);
      tick();
      chk("abort wr_count_before", 32'(bus.wr_count), 32'd37);
      reset = 1'b1;
      tick();
      chk("abort busy",     32'(bus.busy),     32'd0);
      chk("abort fb_we",    32'(bus.fb_we),    32'd0);
      chk("abort wr_count", 32'(bus.wr_count), 32'd0);
      chk("abort done",     32'(bus.done),     32'd0);
      reset = 1'b0;
      tick(); tick(); tick();
      chk("abort no_done",      done_cnt,     0);
      chk("abort no_more_wr",   got_q.size(), 37);
      run_blit(0, 0, "after_abort");

      // start held high across two blits.
      fill_random_rom();
      clear_stats();
      build_expected(7, 3);
      bus.x0    = 8'd7;
      bus.y0    = 7'd3;
      bus.start = 1'b1;
      tick();
      wait_done("held1", 6000);
      check_blit("held1");
      tick();
      chk("held gap_busy", 32'(bus.busy), 32'd0);
      clear_stats();
      tick();
      chk("held restart_busy", 32'(bus.busy), 32'd1);
      wait_done("held2", 6000);
      check_blit("held2");
      bus.start = 1'b0;
      tick();
      chk("held end_busy", 32'(bus.busy), 32'd0);
      tick();
      chk("held no_third", 32'(bus.busy), 32'd0);

      // Randomized origins, ROM contents and back-pressure.
      ready_mode = 2;
      for (int k = 0; k < 4; k++) begin
         fill_random_rom();
         run_blit(int'($urandom_range(0, 175)), int'($urandom_range(0, 127)), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
